// File: rtl/row_byte_loader_if.sv
// Byte-stream in / parallel-row out handshake bundle for row_byte_loader.
// slave = loader side, master = feeder/consumer side.
interface row_byte_loader_if #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ROWS_PER_BLOCK = 4
);
  localparam int unsigned IDX_W = (ROWS_PER_BLOCK > 1) ? $clog2(ROWS_PER_BLOCK) : 1;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out0;
  logic [DATA_W-1:0] out1;
  logic [DATA_W-1:0] out2;
  logic [DATA_W-1:0] out3;
  logic [IDX_W-1:0]  out_row_idx;
  logic              block_done;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out0, out1, out2, out3, out_row_idx, block_done
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out0, out1, out2, out3, out_row_idx, block_done
  );
endinterface

// File: rtl/row_byte_loader.sv
// Assembles 4 serial bytes into a row, holds it until accepted, tracks row index in a block.
// Optional SHIFT_ROWS_EN: rotate each row left by its row index before presenting it.
module row_byte_loader #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ROWS_PER_BLOCK = 4
) (
  input  logic             clock,
  input  logic             reset,
  row_byte_loader_if.slave bus
);
  localparam int unsigned IDX_W = (ROWS_PER_BLOCK > 1) ? $clog2(ROWS_PER_BLOCK) : 1;

  typedef enum logic {FILL, HOLD} state_t;

  state_t             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   row_q, row_d;
  logic [DATA_W-1:0]  slot_q [3];
  logic [DATA_W-1:0]  slot_d [3];
  logic [DATA_W-1:0]  out_q  [4];
  logic [DATA_W-1:0]  out_d  [4];
  logic               done_q, done_d;
  logic [DATA_W-1:0]  row_bytes [4];
  logic [1:0]         rot;
  logic [1:0]         sel;
  logic               accept;
  logic               transfer;

  assign accept   = (state_q == FILL) && bus.in_valid;
  assign transfer = (state_q == HOLD) && bus.out_ready;

  always_ff @(posedge clock) begin
    if (reset) state_q <= FILL;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: if (accept && cnt_q == 2'd3) state_d = HOLD;
      HOLD: if (bus.out_ready)           state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == FILL);
    bus.out_valid = (state_q == HOLD);
  end

`ifdef SHIFT_ROWS_EN
  assign rot = 2'(row_q);
`else
  assign rot = 2'd0;
`endif

  // The 4th byte is never stored in a slot: it feeds the output registers straight from in_data.
  always_comb begin
    row_bytes[0] = slot_q[0];
    row_bytes[1] = slot_q[1];
    row_bytes[2] = slot_q[2];
    row_bytes[3] = bus.in_data;
  end

  always_comb begin
    cnt_d  = cnt_q;
    row_d  = row_q;
    done_d = 1'b0;
    sel    = '0;
    for (int unsigned i = 0; i < 3; i++) slot_d[i] = slot_q[i];
    for (int unsigned j = 0; j < 4; j++) out_d[j]  = out_q[j];
    if (accept) begin
      cnt_d = cnt_q + 2'd1;
      if (cnt_q != 2'd3) begin
        slot_d[cnt_q] = bus.in_data;
      end else begin
        for (int unsigned j = 0; j < 4; j++) begin
          sel      = 2'(j) + rot;
          out_d[j] = row_bytes[sel];
        end
      end
    end
    if (transfer) begin
      row_d  = row_q + IDX_W'(1);
      done_d = (row_q == IDX_W'(ROWS_PER_BLOCK - 1));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      row_q  <= '0;
      done_q <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) slot_q[i] <= '0;
      for (int unsigned j = 0; j < 4; j++) out_q[j]  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      row_q  <= row_d;
      done_q <= done_d;
      for (int unsigned i = 0; i < 3; i++) slot_q[i] <= slot_d[i];
      for (int unsigned j = 0; j < 4; j++) out_q[j]  <= out_d[j];
    end
  end

  // out_row_idx tracks the live index, which only advances as the held row leaves.
  assign bus.out0        = out_q[0];
  assign bus.out1        = out_q[1];
  assign bus.out2        = out_q[2];
  assign bus.out3        = out_q[3];
  assign bus.out_row_idx = row_q;
  assign bus.block_done  = done_q;
endmodule

// File: tb/tb_row_byte_loader.sv
// Directed self-checking bench for row_byte_loader; expectations follow SHIFT_ROWS_EN if defined.
module tb_row_byte_loader;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  row_byte_loader_if #(.DATA_W(8), .ROWS_PER_BLOCK(4)) bus ();

  row_byte_loader #(.DATA_W(8), .ROWS_PER_BLOCK(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_row(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d, input int idx);
    logic [7:0] bytes [4];
    int rot;
    bytes[0] = a; bytes[1] = b; bytes[2] = c; bytes[3] = d;
`ifdef SHIFT_ROWS_EN
    rot = idx % 4;
`else
    rot = 0;
`endif
    check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".out0"},  32'(bus.out0), 32'(bytes[(0 + rot) % 4]));
    check({tag, ".out1"},  32'(bus.out1), 32'(bytes[(1 + rot) % 4]));
    check({tag, ".out2"},  32'(bus.out2), 32'(bytes[(2 + rot) % 4]));
    check({tag, ".out3"},  32'(bus.out3), 32'(bytes[(3 + rot) % 4]));
    check({tag, ".idx"},   32'(bus.out_row_idx), 32'(idx));
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    step();
    bus.in_valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic send_row(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d, input int gap);
    send_byte(a, gap);
    send_byte(b, gap);
    send_byte(c, gap);
    send_byte(d, 0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;

    // Reset for two cycles
    step();
    step();
    check("rst.in_ready",   32'(bus.in_ready), 32'd1);
    check("rst.out_valid",  32'(bus.out_valid), 32'd0);
    check("rst.outs",       {bus.out0, bus.out1, bus.out2, bus.out3}, 32'h0);
    check("rst.idx",        32'(bus.out_row_idx), 32'd0);
    check("rst.block_done", 32'(bus.block_done), 32'd0);
    reset = 1'b0;

    // Row 0, back-to-back bytes, downstream always ready
    bus.out_ready = 1'b1;
    send_row(8'h00, 8'h11, 8'h22, 8'h33, 0);
    check_row("row0", 8'h00, 8'h11, 8'h22, 8'h33, 0);
    check("row0.in_ready", 32'(bus.in_ready), 32'd0);
    step();
    check("row0.valid_drop", 32'(bus.out_valid), 32'd0);
    check("row0.idx_next",   32'(bus.out_row_idx), 32'd1);

    // Row 1: rotation by one when enabled
    send_row(8'h10, 8'h11, 8'h12, 8'h13, 0);
    check_row("row1", 8'h10, 8'h11, 8'h12, 8'h13, 1);
    step();

    // Row 2 under backpressure while 0xFF is offered
    bus.out_ready = 1'b0;
    send_row(8'h20, 8'h21, 8'h22, 8'h23, 0);
    check_row("bp.held", 8'h20, 8'h21, 8'h22, 8'h23, 2);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp.in_ready", 32'(bus.in_ready), 32'd0);
      check_row("bp.stable", 8'h20, 8'h21, 8'h22, 8'h23, 2);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("bp.released", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    send_row(8'h30, 8'h31, 8'h32, 8'h33, 0);
    check_row("bp.fresh", 8'h30, 8'h31, 8'h32, 8'h33, 3);
    check("bp.done_before", 32'(bus.block_done), 32'd0);
    bus.out_ready = 1'b1;
    step();
    check("bp.block_done", 32'(bus.block_done), 32'd1);
    check("bp.idx_wrap",   32'(bus.out_row_idx), 32'd0);
    step();
    check("bp.done_once",  32'(bus.block_done), 32'd0);

    // Full block with one idle cycle between bytes
    for (int r = 0; r < 4; r++) begin
      logic [7:0] base;
      base = 8'(8'h40 + 8'(r * 16));
      send_row(base, base + 8'h1, base + 8'h2, base + 8'h3, 1);
      check_row("blk.row", base, base + 8'h1, base + 8'h2, base + 8'h3, r);
      check("blk.done_hold", 32'(bus.block_done), 32'd0);
      step();
      check("blk.done_after", 32'(bus.block_done), (r == 3) ? 32'd1 : 32'd0);
      step();
      check("blk.done_clear", 32'(bus.block_done), 32'd0);
    end
    send_row(8'h80, 8'h81, 8'h82, 8'h83, 0);
    check_row("blk.next_idx0", 8'h80, 8'h81, 8'h82, 8'h83, 0);
    step();

    // Reset mid-row discards partial bytes
    bus.out_ready = 1'b0;
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid.in_ready",  32'(bus.in_ready), 32'd1);
    check("mid.out_valid", 32'(bus.out_valid), 32'd0);
    check("mid.outs",      {bus.out0, bus.out1, bus.out2, bus.out3}, 32'h0);
    check("mid.idx",       32'(bus.out_row_idx), 32'd0);
    send_row(8'h01, 8'h02, 8'h03, 8'h04, 0);
    check_row("mid.row", 8'h01, 8'h02, 8'h03, 8'h04, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
